prog_loader: RTL and testbench
==============================

# prog_loader

Parametrised program loader that sits between the bench or boot source and the processor's instruction memory. It holds the core in reset and accepts a program as a stream of instruction words over a valid/ready handshake, writing each word into instruction memory. It can optionally read the memory back and check it against an XOR checksum, then releases the core. It generalises the fixed six-word preload to any instruction width and depth, and adds flow control, length checking, readback verification and an error flag.

## Interface
- INST_W, 32, instruction word width in bits
- DEPTH, 16, instruction memory depth in words
- ADDR_W, 4, memory address width; DEPTH <= 2**ADDR_W
- clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load session (sampled in IDLE only)
- len  in  ADDR_W+1  word count for the session, legal 1..DEPTH
- verify_en  in  1  perform readback verify after load (latched at start)
- s_valid  in  1  source word valid
- s_data  in  INST_W  source instruction word
- s_ready  out  1  loader accepts word this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  instruction memory write/read address
- mem_wdata  out  INST_W  instruction memory write data
- mem_rdata  in  INST_W  instruction memory read data, 1-cycle latency from mem_addr
- core_rst  out  1  processor reset, active-high
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end (pass or fail)
- err  out  1  sticky error, cleared by next accepted start or sys_rst
- checksum  out  INST_W  XOR of all words accepted in current session

## Operation
- States: IDLE, LOAD, VERIFY, RELEASE.
- Reset values: state IDLE, core_rst=1, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, checksum=0, counters 0.
- IDLE:
  - start with legal len: latch len and verify_en, clear err/checksum/counters, assert core_rst, go LOAD.
  - start with len=0 or len>DEPTH: set err, pulse done, stay IDLE, core_rst unchanged.
- LOAD:
  - s_ready=1 and busy=1.
  - A transfer occurs when s_valid && s_ready. On a transfer: mem_we=1, mem_addr=word count, mem_wdata=s_data (combinational from s_data), checksum ^= s_data, count increments.
  - Transfer of word len-1: go VERIFY if verify_en, else RELEASE.
  - s_valid low: no write, no count change, wait indefinitely.
- VERIFY:
  - s_ready=0, mem_we=0. Drive mem_addr = 0..len-1 on consecutive cycles.
  - XOR each mem_rdata, arriving one cycle after its address, into a readback accumulator.
  - After the last data word: if the accumulator equals checksum, go RELEASE. Otherwise set err, pulse done, go IDLE with core_rst held at 1.
- RELEASE: for one cycle, then go IDLE with core_rst=0 and done pulsed on that same edge.
- start while busy is ignored. len and verify_en changes during a session are ignored.
- sys_rst in any state returns all outputs to reset values on the next edge, including core_rst=1. A partially written memory is not cleared.

## Timing
- start to s_ready high: 1 cycle.
- LOAD with s_valid held high: exactly len cycles, one write per cycle, addresses 0..len-1 in order.
- VERIFY: len+1 cycles (len address cycles plus 1 latency cycle).
- RELEASE: 1 cycle. core_rst falls and done rises on the same edge, leaving RELEASE.
- Total start to core_rst low without verify: len+2 cycles with no source stalls. With verify: 2*len+3 cycles.
- done is high for exactly 1 cycle per session, including the illegal-len case.
- Word width: checksum and accumulator are INST_W bits. The counter is ADDR_W+1 bits so len=DEPTH terminates without wrap.

## Test plan
- Reset hold: sys_rst high for 5 cycles -> core_rst=1, busy=0, done=0, err=0, checksum=0; after release, core_rst stays 1 until a session completes.
- Basic load, no verify: len=6, six words 0x00000001..0x00000006 with s_valid continuous -> writes to addr 0..5 on 6 consecutive cycles, checksum=0x00000007, done pulse and core_rst=0 at start+8.
- Verify pass and fail: len=4 with verify_en=1 and a correct memory model -> core_rst falls at start+11, err=0. Repeat with the model corrupting addr 2 bit 0 -> err=1, done pulse, core_rst stays 1.
- Backpressure/stalls: len=DEPTH=16 with s_valid toggling every other cycle -> exactly 16 writes, addresses 0..15 with no skips or repeats, no write in stall cycles.
- Illegal length: start with len=0, then len=17 -> err=1 and a 1-cycle done each time, no writes, state stays IDLE. A following legal start clears err.
- Reset mid-load: sys_rst after 3 of 8 words -> next edge busy=0, core_rst=1, checksum=0. A new session then loads correctly from addr 0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Source stream handshake for the program loader.
//   s_valid : source word valid
//   s_data  : source instruction word (INST_W bits)
//   s_ready : loader accepts the word this cycle
// master = boot source / bench side, slave = loader side.
interface prog_loader_if #(
  parameter int INST_W = 32
) ();
  logic              s_valid;
  logic [INST_W-1:0] s_data;
  logic              s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: holds the core in reset, streams a program into
// instruction memory over a valid/ready handshake, optionally reads the
// memory back and checks it against the XOR checksum of the accepted
// words, then releases the core.
//
// Ports:
//   clk, sys_rst     : clock, synchronous active-high reset
//   start_i          : begin a session (sampled in IDLE only)
//   len_i            : word count for the session, legal 1..DEPTH
//   verify_en_i      : do readback verify after the load (latched at start)
//   src              : source stream (s_valid/s_data in, s_ready out)
//   mem_we_o         : instruction memory write enable
//   mem_addr_o       : instruction memory write/read address
//   mem_wdata_o      : instruction memory write data
//   mem_rdata_i      : instruction memory read data, 1 cycle after address
//   core_rst_o       : processor reset, active-high
//   busy_o           : session in progress
//   done_o           : one-cycle pulse at session end (pass or fail)
//   err_o            : sticky error, cleared by next accepted start
//   checksum_o       : XOR of all words accepted in the current session
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; core_rst holds its last value
// ST_LOAD    | accepting words, one memory write per transfer
// ST_VERIFY  | reading memory back, XOR-accumulating against checksum
// ST_RELEASE | one cycle before dropping core_rst and pulsing done
module prog_loader #(
  parameter int INST_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              verify_en_i,
  prog_loader_if.slave      src,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [INST_W-1:0] mem_wdata_o,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [INST_W-1:0] checksum_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_RELEASE
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic              verify_q;
  // Counts accepted words in LOAD, issued read addresses in VERIFY.
  // One bit wider than the address so len=DEPTH ends without wrapping.
  logic [ADDR_W:0]   cnt_q;
  logic [INST_W-1:0] acc_q;
  logic [INST_W-1:0] checksum_q;
  logic              core_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              s_ready_q;

  logic              len_ok_d;
  logic              xfer_d;
  logic              last_load_d;
  logic              rd_issue_d;
  logic              verify_last_d;
  logic [INST_W-1:0] acc_d;

  assign len_ok_d      = (len_i != '0) && (len_i <= DEPTH_L);
  assign xfer_d        = s_ready_q && src.s_valid;
  assign last_load_d   = xfer_d && (cnt_q == len_q - 1'b1);
  assign rd_issue_d    = (state_q == ST_VERIFY) && (cnt_q < len_q);
  assign verify_last_d = (state_q == ST_VERIFY) && (cnt_q == len_q);
  // Read data for address cnt_q-1 is on mem_rdata_i whenever cnt_q != 0.
  assign acc_d         = acc_q ^ mem_rdata_i;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      verify_q   <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      checksum_q <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_ok_d) begin
              len_q      <= len_i;
              verify_q   <= verify_en_i;
              err_q      <= 1'b0;
              checksum_q <= '0;
              acc_q      <= '0;
              cnt_q      <= '0;
              core_rst_q <= 1'b1;
              busy_q     <= 1'b1;
              s_ready_q  <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              // Rejected session: flag it and close it out immediately.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (xfer_d) begin
            checksum_q <= checksum_q ^ src.s_data;
            if (last_load_d) begin
              cnt_q     <= '0;
              s_ready_q <= 1'b0;
              state_q   <= verify_q ? ST_VERIFY : ST_RELEASE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_VERIFY: begin
          if (cnt_q != '0) begin
            acc_q <= acc_d;
          end
          if (verify_last_d) begin
            cnt_q <= '0;
            if (acc_d == checksum_q) begin
              state_q <= ST_RELEASE;
            end else begin
              // Mismatch: core stays in reset, session ends with error.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          core_rst_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data is passed straight through from the source so a word is
  // written on the same cycle it is accepted.
  always_comb begin
    mem_addr_o = '0;
    if (state_q == ST_LOAD || rd_issue_d) begin
      mem_addr_o = cnt_q[ADDR_W-1:0];
    end
  end

  assign mem_we_o    = xfer_d;
  assign mem_wdata_o = xfer_d ? src.s_data : '0;

  assign src.s_ready = s_ready_q;
  assign core_rst_o  = core_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign checksum_o  = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard and a
// one-cycle-latency instruction memory model.
module tb_prog_loader;

  localparam int INST_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              start_i;
  logic [ADDR_W:0]   len_i;
  logic              verify_en_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [INST_W-1:0] mem_wdata_o;
  logic [INST_W-1:0] mem_rdata_i;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [INST_W-1:0] checksum_o;

  prog_loader_if #(.INST_W(INST_W)) src_if ();

  prog_loader #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .start_i     (start_i),
    .len_i       (len_i),
    .verify_en_i (verify_en_i),
    .src         (src_if.slave),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .core_rst_o  (core_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .checksum_o  (checksum_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } wr_t;

  wr_t               sb[$];
  logic [INST_W-1:0] words [DEPTH];
  logic [INST_W-1:0] mem_model [DEPTH];
  bit                corrupt = 1'b0;

  // Memory model: registered read, optional bit-0 corruption at address 2.
  always @(posedge clk) begin
    if (mem_we_o === 1'b1) mem_model[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= mem_model[mem_addr_o] ^
                   {{(INST_W-1){1'b0}}, (corrupt && mem_addr_o == 4'd2)};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write seen must match the next queued expectation.
  always @(negedge clk) begin
    if (sys_rst === 1'b0 && mem_we_o === 1'b1) begin
      check("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(mem_addr_o), 64'(e.addr));
        check("wr_data", 64'(mem_wdata_o), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic session(input int n, input bit ver, input bit stall, input bit bad);
    logic [INST_W-1:0] exp_ck;
    int idx, cyc, waited, exp_wait;
    bit pass;
    pass   = !(ver && bad);
    exp_ck = '0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{addr: ADDR_W'(i), data: words[i]});
      exp_ck ^= words[i];
    end
    corrupt           = bad;
    start_i           = 1'b1;
    len_i             = (ADDR_W+1)'(n);
    verify_en_i       = ver;
    src_if.s_valid    = 1'b0;
    tick();
    start_i = 1'b0;
    check("s_ready_after_start", 64'(src_if.s_ready), 64'd1);
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("core_rst_in_load", 64'(core_rst_o), 64'd1);
    check("err_cleared", 64'(err_o), 64'd0);
    check("checksum_cleared", 64'(checksum_o), 64'd0);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 200) begin
      len_i          = (ADDR_W+1)'($urandom);
      verify_en_i    = 1'($urandom);
      src_if.s_valid = stall ? (cyc % 2 == 0) : 1'b1;
      src_if.s_data  = src_if.s_valid ? words[idx] : INST_W'($urandom);
      tick();
      if (src_if.s_valid) idx++;
      cyc++;
    end
    src_if.s_valid = 1'b0;
    check("load_cycles", 64'(cyc), 64'(stall ? 2*n-1 : n));
    check("checksum", 64'(checksum_o), 64'(exp_ck));
    check("s_ready_after_load", 64'(src_if.s_ready), 64'd0);
    exp_wait = ver ? (pass ? n+2 : n+1) : 1;
    waited = 0;
    while (done_o !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check("done_latency", 64'(waited), 64'(exp_wait));
    check("core_rst_end", 64'(core_rst_o), 64'(!pass));
    check("err_end", 64'(err_o), 64'(!pass));
    check("busy_end", 64'(busy_o), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    tick();
    check("done_one_cycle", 64'(done_o), 64'd0);
    corrupt = 1'b0;
  endtask

  task automatic illegal(input int l);
    logic core_before;
    core_before = core_rst_o;
    start_i     = 1'b1;
    len_i       = (ADDR_W+1)'(l);
    tick();
    start_i = 1'b0;
    check($sformatf("ill%0d_err", l), 64'(err_o), 64'd1);
    check($sformatf("ill%0d_done", l), 64'(done_o), 64'd1);
    check($sformatf("ill%0d_busy", l), 64'(busy_o), 64'd0);
    check($sformatf("ill%0d_ready", l), 64'(src_if.s_ready), 64'd0);
    check($sformatf("ill%0d_core_rst", l), 64'(core_rst_o), 64'(core_before));
    tick();
    check($sformatf("ill%0d_done_drop", l), 64'(done_o), 64'd0);
    check($sformatf("ill%0d_err_sticky", l), 64'(err_o), 64'd1);
    check($sformatf("ill%0d_still_idle", l), 64'(src_if.s_ready), 64'd0);
  endtask

  initial begin
    logic [INST_W-1:0] part_ck;
    sys_rst        = 1'b1;
    start_i        = 1'b0;
    len_i          = '0;
    verify_en_i    = 1'b0;
    src_if.s_valid = 1'b0;
    src_if.s_data  = '0;

    // Reset hold
    repeat (5) tick();
    check("rst_core_rst", 64'(core_rst_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_checksum", 64'(checksum_o), 64'd0);
    check("rst_s_ready", 64'(src_if.s_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    sys_rst = 1'b0;
    repeat (3) tick();
    check("post_rst_core_rst", 64'(core_rst_o), 64'd1);

    // Basic six-word load, no verify
    for (int i = 0; i < 6; i++) words[i] = INST_W'(i + 1);
    session(6, 1'b0, 1'b0, 1'b0);
    check("basic_checksum_7", 64'(checksum_o), 64'h7);

    // Verify pass, then verify fail with a corrupted readback
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    session(4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    session(4, 1'b1, 1'b0, 1'b1);

    // Single-word session releases the core again
    words[0] = 32'hDEAD_BEEF;
    session(1, 1'b0, 1'b0, 1'b0);

    // Illegal lengths leave the core released and write nothing
    illegal(0);
    illegal(DEPTH + 1);

    // Full depth with a stalling source and verify; start clears err
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    session(DEPTH, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a load
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    part_ck = '0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{addr: ADDR_W'(i), data: words[i]});
      part_ck ^= words[i];
    end
    start_i     = 1'b1;
    len_i       = 5'd8;
    verify_en_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_if.s_valid = 1'b1;
      src_if.s_data  = words[i];
      tick();
    end
    src_if.s_valid = 1'b0;
    check("midload_checksum", 64'(checksum_o), 64'(part_ck));
    sys_rst = 1'b1;
    tick();
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_core_rst", 64'(core_rst_o), 64'd1);
    check("midrst_checksum", 64'(checksum_o), 64'd0);
    check("midrst_s_ready", 64'(src_if.s_ready), 64'd0);
    check("midrst_sb_drained", 64'(sb.size()), 64'd0);
    sys_rst = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    session(8, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
